// File: rtl/spike_event_packer_if.sv
// spike_event_packer_if: pipe-out handshake between the event packer and a block-throttled host endpoint.
interface spike_event_packer_if;
   logic        ep_read;
   logic        ep_blockstrobe;
   logic [15:0] ep_datain;
   logic        ep_ready;
   modport master (output ep_read, ep_blockstrobe, input ep_datain, ep_ready);
   modport slave (input ep_read, ep_blockstrobe, output ep_datain, ep_ready);
endinterface

// File: rtl/spike_event_packer.sv
// spike_event_packer: packs spike events and timestep markers into 16-bit words,
// buffers them in a FWFT FIFO and serves them to the host in fixed-size blocks.
module spike_event_packer #(
   parameter int NN          = 8,
   parameter int DEPTH_LOG2  = 10,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  tick,
   input  logic                  spike_valid,
   input  logic [1:0]            spike_src,
   input  logic [NN:0]           spike_idx,
   spike_event_packer_if.slave   ep,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [15:0]           drop_cnt,
   output logic [15:0]           underflow_cnt
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] BLK = (DEPTH_LOG2+1)'(BLOCK_WORDS);
   localparam logic [DEPTH_LOG2:0] BLK_LAST = (DEPTH_LOG2+1)'(BLOCK_WORDS - 1);
   localparam logic [15:0] FILLER = 16'h1E00;
   typedef enum logic {IDLE, BLOCK} state_t;
   state_t                state, state_nxt;
   logic [DEPTH_LOG2:0]   rd_blk, rd_blk_nxt, cnt;
   logic                  ready_nxt, mk, sp, push, pop, wr, full, empty, hold_v;
   logic [14:0]           ts;
   logic [15:0]           hold_w, sw, pw;
   logic [15:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp, rp;
   logic [1:0]            drop_inc;
   logic [16:0]           drop_sum;
   assign mk = enable & tick;
   assign sp = enable & spike_valid;
   assign sw = {1'b0, spike_src, {(12-NN){1'b0}}, spike_idx};
   assign push = mk | hold_v | sp;
   assign pw = mk ? {1'b1, ts} : hold_v ? hold_w : sw;
   assign empty = cnt == '0;
   assign full = cnt == FULL;
   assign pop = ep.ep_read & ~empty;
   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign wr = push & (~full | pop);
   assign drop_inc = 2'(mk & sp & hold_v) + 2'(push & full & ~pop);
   assign drop_sum = 17'(drop_cnt) + 17'(drop_inc);
   assign ep.ep_datain = empty ? FILLER : mem[rp];
   assign fifo_count = cnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ts <= '0;
         hold_v <= 1'b0;
         hold_w <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         drop_cnt <= '0;
         underflow_cnt <= '0;
      end else begin
         if (mk) ts <= ts + 1'b1;
         // the hold slot keeps its spike while a marker owns the write port
         hold_v <= mk ? (hold_v | sp) : (hold_v & sp);
         if (sp & (mk ? ~hold_v : hold_v)) hold_w <= sw;
         if (wr) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (ep.ep_read & empty & ~&underflow_cnt) underflow_cnt <= underflow_cnt + 1'b1;
      end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= pw;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         rd_blk <= '0;
         ep.ep_ready <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_blk <= rd_blk_nxt;
         ep.ep_ready <= ready_nxt;
      end
   always_comb begin
      rd_blk_nxt = ep.ep_blockstrobe ? '0 : (state == BLOCK && ep.ep_read) ? rd_blk + 1'b1 : rd_blk;
      state_nxt = ep.ep_blockstrobe ? BLOCK :
                  (state == BLOCK && ep.ep_read && rd_blk == BLK_LAST) ? IDLE : state;
   end
   always_comb begin
      ready_nxt = state == IDLE && !ep.ep_blockstrobe && cnt >= BLK;
   end
endmodule

// File: doc/spike_event_packer.md
# spike_event_packer

Encodes spike events from the time-multiplexed neuron array (Ia, II, MN populations) and simulation timestep markers into 16-bit words. Buffers them in an internal FIFO and serves them to the host through the block-throttled pipe-out handshake (ep_read / ep_blockstrobe / ep_ready). This is the host-bound counterpart of the waveform pipe-in path: the host drains a compact, timestamped event stream in fixed-size blocks instead of sampling raw spike wires. It sits between the neuron/spike outputs and an okBTPipeOut endpoint, all in one clock domain.

## Interface
- NN, 8, neuron index width is NN+1 bits (matches neuronIndex)
- DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 words
- BLOCK_WORDS, 256, words per pipe-out block; must be ≤ 2^DEPTH_LOG2
- clk  in  1  single clock; the instantiator synchronises all inputs into this domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high = capture events and markers; low = no pushes, reads still served
- tick  in  1  one-cycle pulse per simulation timestep (sim_clk edge)
- spike_valid  in  1  one-cycle pulse per spike
- spike_src  in  2  0=Ia, 1=II, 2=MN, 3=spare
- spike_idx  in  NN+1  neuron index of the spike
- ep_read  in  1  host pop strobe from pipe-out endpoint
- ep_blockstrobe  in  1  one-cycle pulse at block start
- ep_datain  out  16  FIFO head word, or filler when empty
- ep_ready  out  1  a full block is available
- fifo_count  out  DEPTH_LOG2+1  words stored
- drop_cnt  out  16  saturating count of words lost to overflow
- underflow_cnt  out  16  saturating count of reads while empty

## Operation
- Event word: bit15=0, [14:13]=spike_src, [12:NN+1]=0, [NN:0]=spike_idx.
- Marker word: bit15=1, [14:0]=timestep counter ts (15-bit, wraps 0x7FFF→0).
- Filler word: 16'h1E00. Reserved bits are nonzero, so it is distinguishable from every event word for NN≤8.
- On tick with enable=1:
  - Push a marker carrying the current ts.
  - ts increments in the same cycle. The first marker after reset is 16'h8000.
- Write-port priority: marker > held spike > new spike.
  - One-entry hold register absorbs a spike that loses arbitration.
  - spike_valid while the hold register is occupied and cannot drain: the new spike is dropped and drop_cnt increments.
- Push while the FIFO is full (2^DEPTH_LOG2 words): the word is discarded and drop_cnt increments (saturates at 16'hFFFF).
  - Simultaneous pop and push when full: both take effect; nothing is dropped.
- enable=0:
  - tick and spike_valid are ignored and ts holds.
  - The hold register still drains.
- Read side:
  - ep_datain always presents the head word (first-word-fall-through).
  - ep_read=1 pops the head.
  - ep_read while empty: no pop, ep_datain=16'h1E00, underflow_cnt increments (saturating).
- Block control, states IDLE and BLOCK:
  - IDLE: ep_ready = (fifo_count ≥ BLOCK_WORDS), registered.
  - ep_blockstrobe in IDLE → BLOCK. Clear the read counter rd_blk; ep_ready=0.
  - BLOCK: each ep_read increments rd_blk. When rd_blk reaches BLOCK_WORDS → IDLE.
  - ep_blockstrobe in BLOCK restarts the count (rd_blk=0).
- Reset (reset_n low, any time, including mid-block):
  - FIFO empty, hold register empty, ts=0, drop_cnt=0, underflow_cnt=0, state IDLE.
  - ep_ready=0, fifo_count=0, ep_datain=16'h1E00.

## Timing
- Push latency:
  - A pushed word is counted in fifo_count the cycle after the push.
  - If the FIFO was empty, the word appears on ep_datain the cycle after the push.
- A held spike is written the cycle after its arbitration loss (absent another tick).
- Pop: ep_read in cycle t consumes the word shown in t; the next head is on ep_datain in t+1. Back-to-back ep_read every cycle is supported with no bubbles.
- ep_ready updates one cycle after a fifo_count or state change, and drops in the cycle after ep_blockstrobe.
- ts increments 1 cycle after tick; the marker carries the pre-increment value.
- Throughput: one FIFO write per cycle, one read per cycle, concurrently.

## Test plan
- Reset, then tick twice with enable=1, then read 2 words → 16'h8000, 16'h8001. A third read → 16'h1E00 with underflow_cnt=1.
- spike_valid with src=2, idx=9'h05A in the same cycle as tick → reads 16'h8000 then 16'h405A; drop_cnt=0.
- Push 2^DEPTH_LOG2+3 events with no reads → fifo_count=1024, drop_cnt=3. Drain: all words in push order.
- Load 300 words → ep_ready=1. Then:
  - Blockstrobe → ep_ready=0 next cycle.
  - 256 reads → state IDLE; 44 remain, ep_ready stays 0.
  - Add 212 words → ep_ready=1.
- Assert reset_n low mid-block, after 100 of 256 reads → all counters 0, ep_ready=0, ep_datain=16'h1E00. The next tick produces 16'h8000.
- Preload ts to 0x7FFF via 32767 ticks, then two ticks → markers 16'hFFFF then 16'h8000 (wrap).
